// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: per-state mux selects, write strobes, branch resolve.
// Latency with MemReady=1: lw 5 cycles, sw/R/I/jal 4, branch/lui 3; outputs are combinational from state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold (strobes re-asserted) until MemReady; each stall adds one cycle.
module multicycle_controller #(
    parameter int STATEW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              Carry,
    input  logic              Neg,
    input  logic              Overflow,
    input  logic              MemReady,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              RegWrite,
    output logic [2:0]        ImmSrc,
    output logic [3:0]        ALUControl,
    output logic              Retire,
    output logic              Illegal,
    output logic [STATEW-1:0] State
);

    localparam logic [STATEW-1:0] FETCH    = STATEW'(0);
    localparam logic [STATEW-1:0] DECODE   = STATEW'(1);
    localparam logic [STATEW-1:0] MEMADR   = STATEW'(2);
    localparam logic [STATEW-1:0] MEMREAD  = STATEW'(3);
    localparam logic [STATEW-1:0] MEMWB    = STATEW'(4);
    localparam logic [STATEW-1:0] MEMWRITE = STATEW'(5);
    localparam logic [STATEW-1:0] EXECR    = STATEW'(6);
    localparam logic [STATEW-1:0] EXECI    = STATEW'(7);
    localparam logic [STATEW-1:0] ALUWB    = STATEW'(8);
    localparam logic [STATEW-1:0] BRANCH   = STATEW'(9);
    localparam logic [STATEW-1:0] JAL      = STATEW'(10);
    localparam logic [STATEW-1:0] LUI      = STATEW'(11);
    localparam logic [STATEW-1:0] TRAP     = STATEW'(12);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    logic [STATEW-1:0] state;
    logic [STATEW-1:0] state_next;
    logic              illegal_q;
    logic              taken;
    logic [3:0]        alu_funct;
    logic              pcwrite_raw;
    logic              irwrite_raw;
    logic              regwrite_raw;
    logic              memwrite_raw;
    logic              retire_raw;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Illegal flag latches on the way into TRAP and stays until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   illegal_q <= 1'b0;
        else if (state_next == TRAP) illegal_q <= 1'b1;
    end

    // Branch condition from ALU flags of rs1 - rs2; 010/011 are not branches.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = Neg ^ Overflow;
            3'b101:  taken = ~(Neg ^ Overflow);
            3'b110:  taken = Carry;
            3'b111:  taken = ~Carry;
            default: taken = 1'b0;
        endcase
    end

    // ALU operation for R/I arithmetic; sub only for R-type (op[5]) with funct7b5.
    always_comb begin
        alu_funct = ALU_ADD;
        case (funct3)
            3'b000:  alu_funct = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_funct = ALU_SLL;
            3'b010:  alu_funct = ALU_SLT;
            3'b011:  alu_funct = ALU_SLTU;
            3'b100:  alu_funct = ALU_XOR;
            3'b101:  alu_funct = ALU_SRL;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

    // Per-state selects, raw strobes and next-state decode.
    always_comb begin
        state_next   = state;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUControl   = ALU_ADD;
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        retire_raw   = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                irwrite_raw = MemReady;
                pcwrite_raw = MemReady;
                if (MemReady) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BR:        state_next = BRANCH;
                    OP_JAL:       state_next = JAL;
                    OP_LUI:       state_next = LUI;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc    = 2'b01;
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
                state_next   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
                retire_raw   = MemReady;
                if (MemReady) state_next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
                state_next = ALUWB;
            end
            ALUWB: begin
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
                state_next   = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 2'b10;
                ALUControl  = ALU_SUB;
                pcwrite_raw = taken;
                retire_raw  = 1'b1;
                state_next  = FETCH;
            end
            JAL: begin
                // PC takes the target computed in DECODE; ALU forms OldPC+4 for the link.
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                pcwrite_raw = 1'b1;
                state_next  = ALUWB;
            end
            LUI: begin
                ResultSrc    = 2'b11;
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
                state_next   = FETCH;
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Strobes are suppressed while reset is held so an aborted instruction writes nothing.
    always_comb begin
        PCWrite  = pcwrite_raw  & ~reset;
        IRWrite  = irwrite_raw  & ~reset;
        RegWrite = regwrite_raw & ~reset;
        MemWrite = memwrite_raw & ~reset;
        Retire   = retire_raw   & ~reset;
        Illegal  = illegal_q;
        State    = state;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle.
// Inputs change #1 after the rising edge; outputs are sampled #1 later.
// No DUT-event waits: every sequence is a fixed number of clock steps.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, Carry, Neg, Overflow;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [3:0] State;

    int n_cmp;
    int n_bad;

    multicycle_controller #(.STATEW(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Carry(Carry), .Neg(Neg), .Overflow(Overflow), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Retire(Retire), .Illegal(Illegal),
        .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {PCWrite, IRWrite, RegWrite, MemWrite, Retire};
    endfunction

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; Carry = 1'b0; Neg = 1'b0; Overflow = 1'b0; MemReady = 1'b1;
        tick(); tick();
        #1;
        chk("rst_state", State, 4'd0);
        chk("rst_illegal", Illegal, 1'b0);
        chk("rst_strobes", strobes(), 5'b00000);

        // lw, MemReady high throughout: states 0,1,2,3,4
        reset = 1'b0; #1;
        chk("lw_fetch_state", State, 4'd0);
        chk("lw_fetch_strobes", strobes(), 5'b11000);
        chk("lw_fetch_alub", ALUSrcB, 2'b10);
        chk("lw_fetch_res", ResultSrc, 2'b10);
        tick();
        chk("lw_decode_state", State, 4'd1);
        chk("lw_decode_srcs", {ALUSrcA, ALUSrcB}, 4'b0101);
        chk("lw_imm", ImmSrc, 3'b000);
        tick();
        chk("lw_memadr_state", State, 4'd2);
        chk("lw_memadr_srcs", {ALUSrcA, ALUSrcB}, 4'b1001);
        chk("lw_memadr_strobes", strobes(), 5'b00000);
        tick();
        chk("lw_memread_state", State, 4'd3);
        chk("lw_memread_adr", AdrSrc, 1'b1);
        chk("lw_memread_strobes", strobes(), 5'b00000);
        tick();
        chk("lw_memwb_state", State, 4'd4);
        chk("lw_memwb_strobes", strobes(), 5'b00101);
        chk("lw_memwb_res", ResultSrc, 2'b01);
        tick();
        chk("lw_done_state", State, 4'd0);

        // FETCH stall: MemReady low holds FETCH without enables
        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1; MemReady = 1'b0; #1;
        chk("fetch_stall_strobes", strobes(), 5'b00000);
        tick();
        chk("fetch_stall_state", State, 4'd0);
        MemReady = 1'b1; #1;
        chk("fetch_go_strobes", strobes(), 5'b11000);

        // beq taken
        tick();
        chk("beq_imm", ImmSrc, 3'b010);
        tick();
        chk("beq_state", State, 4'd9);
        chk("beq_alu", ALUControl, 4'b0001);
        chk("beq_strobes", strobes(), 5'b10001);
        tick();
        chk("beq_done_state", State, 4'd0);

        // bltu not taken (Carry=0)
        funct3 = 3'b110; Zero = 1'b0; Carry = 1'b0;
        tick(); tick();
        chk("bltu_state", State, 4'd9);
        chk("bltu_strobes", strobes(), 5'b00001);
        // same state, other conditions evaluated combinationally
        Carry = 1'b1; #1;
        chk("bltu_c1_pcw", PCWrite, 1'b1);
        funct3 = 3'b100; Neg = 1'b1; Overflow = 1'b1; #1;
        chk("blt_nv11_pcw", PCWrite, 1'b0);
        Overflow = 1'b0; #1;
        chk("blt_n1_pcw", PCWrite, 1'b1);
        funct3 = 3'b101; #1;
        chk("bge_n1_pcw", PCWrite, 1'b0);
        funct3 = 3'b010; Zero = 1'b1; #1;
        chk("b010_pcw", PCWrite, 1'b0);
        tick();
        chk("bltu_done_state", State, 4'd0);
        Neg = 1'b0; Carry = 1'b0; Zero = 1'b0;

        // sw with two wait cycles in MEMWRITE: 6 cycles total
        op = 7'b0100011; funct3 = 3'b010;
        tick();
        chk("sw_imm", ImmSrc, 3'b001);
        tick();
        MemReady = 1'b0;
        tick();
        chk("sw_w0_state", State, 4'd5);
        chk("sw_w0_strobes", strobes(), 5'b00010);
        chk("sw_w0_adr", AdrSrc, 1'b1);
        tick();
        chk("sw_w1_state", State, 4'd5);
        chk("sw_w1_strobes", strobes(), 5'b00010);
        MemReady = 1'b1; #1;
        chk("sw_w2_strobes", strobes(), 5'b00011);
        tick();
        chk("sw_done_state", State, 4'd0);

        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();
        chk("r_state", State, 4'd6);
        chk("r_sub", ALUControl, 4'b0001);
        chk("r_srcs", {ALUSrcA, ALUSrcB}, 4'b1000);
        tick();
        chk("r_aluwb_state", State, 4'd8);
        chk("r_aluwb_strobes", strobes(), 5'b00101);
        chk("r_aluwb_res", ResultSrc, 2'b00);
        tick();

        // I-type with same fields: add, then other funct3 codes
        op = 7'b0010011;
        tick(); tick();
        chk("i_state", State, 4'd7);
        chk("i_add", ALUControl, 4'b0000);
        chk("i_srcs", {ALUSrcA, ALUSrcB}, 4'b1001);
        funct3 = 3'b011; #1;
        chk("i_sltu", ALUControl, 4'b1000);
        funct3 = 3'b101; #1;
        chk("i_srl", ALUControl, 4'b0111);
        funct3 = 3'b111; #1;
        chk("i_and", ALUControl, 4'b0010);
        tick(); tick();
        chk("i_done_state", State, 4'd0);

        // jal
        op = 7'b1101111; funct7b5 = 1'b0;
        tick();
        chk("jal_imm", ImmSrc, 3'b011);
        tick();
        chk("jal_state", State, 4'd10);
        chk("jal_strobes", strobes(), 5'b10000);
        chk("jal_srcs", {ALUSrcA, ALUSrcB}, 4'b0110);
        tick();
        chk("jal_aluwb_state", State, 4'd8);
        chk("jal_aluwb_strobes", strobes(), 5'b00101);
        tick();

        // lui
        op = 7'b0110111;
        tick(); tick();
        chk("lui_state", State, 4'd11);
        chk("lui_res", ResultSrc, 2'b11);
        chk("lui_imm", ImmSrc, 3'b100);
        chk("lui_strobes", strobes(), 5'b00101);
        tick();
        chk("lui_done_state", State, 4'd0);

        // illegal opcode traps and stays silent
        op = 7'b0000000;
        tick();
        chk("trap_imm", ImmSrc, 3'b000);
        tick();
        chk("trap_state", State, 4'd12);
        chk("trap_illegal", Illegal, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("trap_hold", {State, strobes(), Illegal}, {4'd12, 5'b00000, 1'b1});
            tick();
        end
        reset = 1'b1; #1;
        chk("trap_rst_state", State, 4'd0);
        chk("trap_rst_illegal", Illegal, 1'b0);
        chk("trap_rst_strobes", strobes(), 5'b00000);
        tick();
        reset = 1'b0;

        // reset during MEMWB aborts the write
        op = 7'b0000011; #1;
        tick(); tick(); tick(); tick();
        chk("abort_pre_state", State, 4'd4);
        chk("abort_pre_regw", RegWrite, 1'b1);
        reset = 1'b1; #1;
        chk("abort_regw", RegWrite, 1'b0);
        chk("abort_state", State, 4'd0);
        chk("abort_retire", Retire, 1'b0);
        tick();
        chk("abort_hold_strobes", strobes(), 5'b00000);
        reset = 1'b0; #1;
        chk("abort_release_state", State, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I core variant; replaces the single-cycle main decoder.
- Shares one memory port, one ALU and one result bus across instruction phases by driving per-state mux selects and write strobes.
- Evaluates branch conditions from ALU flags.
- Memory accesses wait on a ready handshake.

Parameters:
- STATEW, 4, width of the State debug output; must be 4 or more.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- op  input  7  Instr[6:0], from the instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero, Carry, Neg, Overflow  input  1 each  ALU flags; Carry=1 means SrcA<SrcB unsigned
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  data store strobe
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 register A
- ALUSrcB  output  2  00=register B, 01=ImmExt, 10=constant 4
- RegWrite  output  1  register file write strobe
- ImmSrc  output  3  000=I, 001=S, 010=B, 011=J, 100=U
- ALUControl  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sltu
- Retire  output  1  one-cycle pulse in the last cycle of each instruction
- Illegal  output  1  sticky; unsupported opcode was decoded
- State  output  STATEW  current state, for debug

Behaviour:
- Reset (async): State=FETCH(0) and Illegal=0. While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and Retire are forced to 0.
- Reset mid-instruction aborts the instruction with no register or memory write.
- Outputs are combinational from state, op, funct3, funct7b5, flags and MemReady (Moore plus gated strobes). Unlisted strobes are 0 and selects are 00.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Goes to DECODE when MemReady=1, otherwise stays.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op=lw, MEMWRITE if op=sw.
- MEMREAD: AdrSrc=1. Goes to MEMWB when MemReady=1, otherwise stays.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until MemReady=1. Retire=MemReady. Goes to FETCH when MemReady=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct decode, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, funct decode, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Retire=1, then FETCH.
  - PCWrite=taken. Taken by funct3: 000 Zero; 001 ~Zero; 100 Neg^Overflow; 101 ~(Neg^Overflow); 110 Carry; 111 ~Carry; 010/011 never taken.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC<=target held in ALUOut), then ALUWB (rd<=OldPC+4).
- LUI: ResultSrc=11, RegWrite=1, Retire=1, then FETCH.
- TRAP: all strobes 0, Illegal=1. Stays in TRAP until reset.
- Funct decode:
  - funct3 000 -> sub if op[5]&funct7b5, else add.
  - 111 and, 110 or, 100 xor, 010 slt, 011 sltu, 001 sll, 101 srl.
  - funct7b5 is ignored for I-type.
- ImmSrc by op: lw/I-type 000, sw 001, branch 010, jal 011, lui 100. Driven in every state; unknown op gives 000.
- Latency with MemReady=1: lw 5 cycles, sw/R/I/jal 4, branch/lui 3. Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- lw (op 0000011), MemReady=1 -> states 0,1,2,3,4; RegWrite=1 only in state 4 with ResultSrc=01; one Retire pulse.
- beq with Zero=1 -> PCWrite=1 in BRANCH; bltu with Carry=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- sw with MemReady low for 2 cycles in MEMWRITE -> MemWrite held 3 cycles, Retire only in the third, total 6 cycles.
- R-type funct3=000, funct7b5=1 -> ALUControl=0001 in EXECR; I-type with the same fields -> 0000; funct3=011 -> 1000.
- op=0000000 -> TRAP (12), Illegal=1, no strobes for 20 cycles; reset -> FETCH, Illegal=0.
- Reset asserted during MEMWB -> RegWrite drops immediately, State=0, no write occurs.
